// File: rtl/cg_iteration_sequencer_pkg.sv
// Shared definitions for the conjugate-gradient iteration sequencer: defaults,
// state encoding and the beat-count helper.
package cg_iteration_sequencer_pkg;

   localparam int unsigned NU_DEFAULT         = 8;
   localparam int unsigned EW_DEFAULT         = 32;
   localparam int unsigned ITER_WIDTH_DEFAULT = 16;
   localparam logic [31:0] TOLERANCE_DEFAULT  = 32'h283424DC;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RSOLD,
      ST_MATVEC,
      ST_ALPHA,
      ST_UPDATE,
      ST_RSNEW,
      ST_CHECK,
      ST_BETA,
      ST_PUPD,
      ST_DONE
   } state_e;

   // Beats per vector pass; an empty vector still streams one beat.
   function automatic logic [31:0] calc_beats(input logic [31:0] total, input int unsigned nu);
      logic [32:0] sum;
      sum = {1'b0, total} + 33'(nu - 1);
      if (total == 32'd0) return 32'd1;
      return 32'(sum / 33'(nu));
   endfunction

endpackage

// File: rtl/cg_iteration_sequencer_if.sv
// Control/status bundle between the sequencer and the Alu stage chain.
interface cg_iteration_sequencer_if #(
   parameter int unsigned EW = 32,
   parameter int unsigned IW = 16
);

   logic          go;
   logic [31:0]   total;
   logic [IW-1:0] max_iter;
   logic          vxv1_finish;
   logic [EW-1:0] vxv1_result;
   logic          mxv_finish;
   logic          div1_finish;
   logic          mul_add2_finish;
   logic          vxv3_finish;
   logic [EW-1:0] vxv3_result;
   logic          div2_finish;
   logic          mul_add3_finish;

   logic          reset_vxv1;
   logic          reset_mxv1;
   logic          vxv1_read;
   logic          start_mul_add;
   logic          vxv3_start;
   logic          vxv3_read;
   logic          start_div2;
   logic          mul_add3_start;
   logic [EW-1:0] rsold;
   logic [EW-1:0] rsnew;
   logic [IW-1:0] iter_count;
   logic          busy;
   logic          done;
   logic          converged;
   logic          limit_hit;

   modport master (
      output go, total, max_iter, vxv1_finish, vxv1_result, mxv_finish, div1_finish,
             mul_add2_finish, vxv3_finish, vxv3_result, div2_finish, mul_add3_finish,
      input  reset_vxv1, reset_mxv1, vxv1_read, start_mul_add, vxv3_start, vxv3_read,
             start_div2, mul_add3_start, rsold, rsnew, iter_count, busy, done,
             converged, limit_hit
   );

   modport slave (
      input  go, total, max_iter, vxv1_finish, vxv1_result, mxv_finish, div1_finish,
             mul_add2_finish, vxv3_finish, vxv3_result, div2_finish, mul_add3_finish,
      output reset_vxv1, reset_mxv1, vxv1_read, start_mul_add, vxv3_start, vxv3_read,
             start_div2, mul_add3_start, rsold, rsnew, iter_count, busy, done,
             converged, limit_hit
   );

endinterface

// File: rtl/cg_iteration_sequencer_read_pacer.sv
// Operand-read pacer: one strobe every other cycle while enabled, stopping after
// beats_i strobes; dropping enable restarts the pass.
module cg_iteration_sequencer_read_pacer (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable_i,
   input  logic [31:0] beats_i,
   output logic        read_o
);

   logic [31:0] sent_q;
   logic        phase_q;
   logic        done_q;
   logic        last_beat;

   assign last_beat = (sent_q == beats_i - 32'd1);
   assign read_o    = enable_i && !phase_q && !done_q;

   // NOTE: reset is asynchronous and active-low, so it sits in the sensitivity list.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sent_q  <= '0;
         phase_q <= 1'b0;
         done_q  <= 1'b0;
      end else if (!enable_i) begin
         sent_q  <= '0;
         phase_q <= 1'b0;
         done_q  <= 1'b0;
      end else if (read_o) begin
         sent_q  <= sent_q + 32'd1;
         phase_q <= 1'b1;
         done_q  <= last_beat;
      end else begin
         phase_q <= 1'b0;
      end
   end

endmodule

// File: rtl/cg_iteration_sequencer.sv
// Sequences one conjugate-gradient iteration across the Alu stage chain and
// loops until rsnew meets the tolerance or the iteration limit is reached.
module cg_iteration_sequencer
   import cg_iteration_sequencer_pkg::*;
#(
   parameter int unsigned               NO_OF_UNITS   = NU_DEFAULT,
   parameter int unsigned               ELEMENT_WIDTH = EW_DEFAULT,
   parameter logic [ELEMENT_WIDTH-1:0]  TOLERANCE     = ELEMENT_WIDTH'(TOLERANCE_DEFAULT),
   parameter int unsigned               ITER_WIDTH    = ITER_WIDTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   cg_iteration_sequencer_if.slave  bus
);

   state_e                   state_q, state_d;
   logic [31:0]              beats_q;
   logic [ELEMENT_WIDTH-1:0] rsold_q, rsnew_q;
   logic [ITER_WIDTH-1:0]    iter_q;
   logic                     converged_q, limit_hit_q, mul_add3_start_q;

   logic                     start_solve, converge_now, limit_now;
   logic [ITER_WIDTH:0]      iter_inc;
   logic [ITER_WIDTH-1:0]    iter_sat;

   assign start_solve  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.go;
   // Unsigned compare of raw bits orders non-negative IEEE-754 values correctly.
   assign converge_now = (rsnew_q <= TOLERANCE);
   assign iter_inc     = {1'b0, iter_q} + {{ITER_WIDTH{1'b0}}, 1'b1};
   assign iter_sat     = (&iter_q) ? iter_q : iter_inc[ITER_WIDTH-1:0];
   assign limit_now    = (bus.max_iter != '0) && (iter_inc == {1'b0, bus.max_iter});

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (bus.go)              state_d = ST_RSOLD;
         ST_RSOLD:         if (bus.vxv1_finish)     state_d = ST_MATVEC;
         ST_MATVEC:        if (bus.mxv_finish)      state_d = ST_ALPHA;
         ST_ALPHA:         if (bus.div1_finish)     state_d = ST_UPDATE;
         ST_UPDATE:        if (bus.mul_add2_finish) state_d = ST_RSNEW;
         ST_RSNEW:         if (bus.vxv3_finish)     state_d = ST_CHECK;
         ST_CHECK:         state_d = converge_now ? ST_DONE : ST_BETA;
         ST_BETA:          if (bus.div2_finish)     state_d = ST_PUPD;
         ST_PUPD:          if (bus.mul_add3_finish) state_d = limit_now ? ST_DONE : ST_MATVEC;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      bus.reset_vxv1    = 1'b1;
      bus.reset_mxv1    = 1'b1;
      bus.start_mul_add = 1'b0;
      bus.vxv3_start    = 1'b0;
      bus.start_div2    = 1'b0;
      bus.busy          = 1'b1;
      bus.done          = 1'b0;
      case (state_q)
         ST_IDLE:            bus.busy          = 1'b0;
         ST_RSOLD:           bus.reset_vxv1    = 1'b0;
         ST_MATVEC:          bus.reset_mxv1    = 1'b0;
         ST_UPDATE:          bus.start_mul_add = 1'b1;
         ST_RSNEW, ST_CHECK: bus.vxv3_start    = 1'b1;
         ST_BETA, ST_PUPD: begin
            bus.vxv3_start = 1'b1;
            bus.start_div2 = 1'b1;
         end
         ST_DONE: begin
            bus.busy = 1'b0;
            bus.done = 1'b1;
         end
         default: ;
      endcase
   end

   // Latched dot products, iteration count and status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beats_q          <= '0;
         rsold_q          <= '0;
         rsnew_q          <= '0;
         iter_q           <= '0;
         converged_q      <= 1'b0;
         limit_hit_q      <= 1'b0;
         mul_add3_start_q <= 1'b0;
      end else begin
         mul_add3_start_q <= (state_q == ST_BETA) && bus.div2_finish;
         if (start_solve) begin
            beats_q     <= calc_beats(bus.total, NO_OF_UNITS);
            iter_q      <= '0;
            converged_q <= 1'b0;
            limit_hit_q <= 1'b0;
         end
         if ((state_q == ST_RSOLD) && bus.vxv1_finish) rsold_q <= bus.vxv1_result;
         if ((state_q == ST_RSNEW) && bus.vxv3_finish) rsnew_q <= bus.vxv3_result;
         if ((state_q == ST_CHECK) && converge_now)    converged_q <= 1'b1;
         if ((state_q == ST_PUPD) && bus.mul_add3_finish) begin
            iter_q <= iter_sat;
            if (limit_now) limit_hit_q <= 1'b1;
            else           rsold_q     <= rsnew_q;
         end
      end
   end

   cg_iteration_sequencer_read_pacer u_vxv1_pacer (
      .clk      (clk),
      .reset    (reset),
      .enable_i (state_q == ST_RSOLD),
      .beats_i  (beats_q),
      .read_o   (bus.vxv1_read)
   );

   cg_iteration_sequencer_read_pacer u_vxv3_pacer (
      .clk      (clk),
      .reset    (reset),
      .enable_i (state_q == ST_RSNEW),
      .beats_i  (beats_q),
      .read_o   (bus.vxv3_read)
   );

   assign bus.rsold          = rsold_q;
   assign bus.rsnew          = rsnew_q;
   assign bus.iter_count     = iter_q;
   assign bus.converged      = converged_q;
   assign bus.limit_hit      = limit_hit_q;
   assign bus.mul_add3_start = mul_add3_start_q;

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Self-checking bench for cg_iteration_sequencer: expected solve outcomes are
// queued at go and compared when done rises; step-level checks cover pacing.
module tb_cg_iteration_sequencer;

   localparam logic [31:0] TOL = 32'h283424DC;
   localparam int F_VXV1 = 0, F_MXV = 1, F_DIV1 = 2, F_MA2 = 3,
                  F_VXV3 = 4, F_DIV2 = 5, F_MA3 = 6;

   typedef struct packed {
      logic        converged;
      logic        limit_hit;
      logic [15:0] iter;
      logic [31:0] rsold;
      logic [31:0] rsnew;
   } exp_t;

   logic clk;
   logic reset;
   int   n_cmp, n_err;
   int   rd1, rd3, div2_cycles;
   exp_t sb_q[$];

   cg_iteration_sequencer_if #(.EW(32), .IW(16)) bus ();

   cg_iteration_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance to the next falling edge and tally strobes seen there.
   task automatic step();
      @(negedge clk);
      if (bus.vxv1_read)  rd1++;
      if (bus.vxv3_read)  rd3++;
      if (bus.start_div2) div2_cycles++;
   endtask

   task automatic set_fin(input int sel, input logic v);
      case (sel)
         F_VXV1:  bus.vxv1_finish     = v;
         F_MXV:   bus.mxv_finish      = v;
         F_DIV1:  bus.div1_finish     = v;
         F_MA2:   bus.mul_add2_finish = v;
         F_VXV3:  bus.vxv3_finish     = v;
         F_DIV2:  bus.div2_finish     = v;
         default: bus.mul_add3_finish = v;
      endcase
   endtask

   task automatic pulse(input int sel);
      set_fin(sel, 1'b1);
      step();
      set_fin(sel, 1'b0);
   endtask

   function automatic exp_t predict(input logic [31:0] r1, input logic [31:0] r3,
                                    input logic [15:0] mi);
      exp_t e;
      e.rsnew = r3;
      if (r3 <= TOL) begin
         e.converged = 1'b1; e.limit_hit = 1'b0; e.iter = 16'd0; e.rsold = r1;
      end else begin
         e.converged = 1'b0; e.limit_hit = 1'b1; e.iter = mi;
         e.rsold = (mi == 16'd1) ? r1 : r3;
      end
      return e;
   endfunction

   task automatic wait_done(input int budget);
      exp_t e;
      int   n;
      n = 0;
      while (!bus.done && n < budget) begin
         step();
         n++;
      end
      check("done_seen", 64'(bus.done), 64'(1));
      if (!bus.done) return;
      check("sb_depth", 64'(sb_q.size()), 64'(1));
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check("sb_converged", 64'(bus.converged),  64'(e.converged));
      check("sb_limit_hit", 64'(bus.limit_hit),  64'(e.limit_hit));
      check("sb_iter",      64'(bus.iter_count), 64'(e.iter));
      check("sb_rsold",     64'(bus.rsold),      64'(e.rsold));
      check("sb_rsnew",     64'(bus.rsnew),      64'(e.rsnew));
      check("sb_busy",      64'(bus.busy),       64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [5:0] pat;
      int         base1, base3, base_div2;

      n_cmp = 0; n_err = 0; rd1 = 0; rd3 = 0; div2_cycles = 0;
      reset = 1'b0;
      bus.go = 1'b0; bus.total = '0; bus.max_iter = '0;
      bus.vxv1_result = '0; bus.vxv3_result = '0;
      for (int i = 0; i < 7; i++) set_fin(i, 1'b0);
      step(); step();
      check("reset_levels",
            64'({bus.reset_vxv1, bus.reset_mxv1, bus.vxv1_read, bus.start_mul_add, bus.vxv3_start,
                 bus.vxv3_read, bus.start_div2, bus.mul_add3_start, bus.busy, bus.done,
                 bus.converged, bus.limit_hit}), 64'(12'b1100_0000_0000));
      check("reset_iter", 64'(bus.iter_count), 64'(0));
      reset = 1'b1;
      step();

      // T1/T3/T6: two-beat solve that converges on the first rsnew.
      bus.total = 32'd16; bus.max_iter = 16'd0;
      sb_q.push_back(predict(32'h3F800000, 32'h28000000, 16'd0));
      base_div2 = div2_cycles;
      bus.go = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         pat[i] = bus.vxv1_read;
         if (i == 0) bus.go = 1'b0;
         if (i == 2) begin bus.div1_finish = 1'b1; bus.go = 1'b1; end
         if (i == 3) begin bus.div1_finish = 1'b0; bus.go = 1'b0; end
      end
      check("t1_strobe_pattern", 64'(pat), 64'(6'b000101));
      check("t6_still_rsold", 64'({bus.reset_vxv1, bus.reset_mxv1, bus.start_mul_add}), 64'(3'b010));
      bus.vxv1_result = 32'h3F800000;
      pulse(F_VXV1);
      check("t1_rsold", 64'(bus.rsold), 64'(32'h3F800000));
      check("t1_mxv_released", 64'({bus.reset_vxv1, bus.reset_mxv1}), 64'(2'b10));
      bus.go = 1'b1; step(); bus.go = 1'b0;
      check("t6_go_busy_ignored", 64'({bus.reset_mxv1, bus.busy}), 64'(2'b01));
      pulse(F_MXV);
      check("t1_alpha", 64'({bus.reset_mxv1, bus.start_mul_add}), 64'(2'b10));
      pulse(F_DIV1);
      check("t1_update", 64'(bus.start_mul_add), 64'(1));
      base3 = rd3;
      pulse(F_MA2);
      check("t1_rsnew_levels", 64'({bus.start_mul_add, bus.vxv3_start}), 64'(2'b01));
      repeat (6) step();
      check("t1_vxv3_strobes", 64'(rd3 - base3), 64'(2));
      bus.vxv3_result = 32'h28000000;
      pulse(F_VXV3);
      wait_done(20);
      check("t3_no_div2", 64'(div2_cycles - base_div2), 64'(0));

      // T2/T4: three-beat passes, two full loops ending on the iteration limit.
      bus.total = 32'd20; bus.max_iter = 16'd2;
      sb_q.push_back(predict(32'h3F800000, 32'h3F000000, 16'd2));
      base1 = rd1;
      bus.go = 1'b1; step(); bus.go = 1'b0;
      check("t4_go_clears", 64'({bus.converged, bus.done, bus.busy}), 64'(3'b001));
      repeat (8) step();
      check("t2_vxv1_strobes", 64'(rd1 - base1), 64'(3));
      pulse(F_VXV1);
      for (int loop = 0; loop < 2; loop++) begin
         pulse(F_MXV);
         pulse(F_DIV1);
         base3 = rd3;
         pulse(F_MA2);
         repeat (8) step();
         check("t2_vxv3_strobes", 64'(rd3 - base3), 64'(3));
         bus.vxv3_result = 32'h3F000000;
         pulse(F_VXV3);
         step();
         check("t4_beta_level", 64'(bus.start_div2), 64'(1));
         pulse(F_DIV2);
         check("t4_ma3_pulse_hi", 64'(bus.mul_add3_start), 64'(1));
         step();
         check("t4_ma3_pulse_lo", 64'(bus.mul_add3_start), 64'(0));
         base1 = rd1;
         pulse(F_MA3);
         if (loop == 0) begin
            check("t4_iter1", 64'(bus.iter_count), 64'(1));
            check("t4_rsold_reuse", 64'(bus.rsold), 64'(32'h3F000000));
            check("t4_skip_rsold", 64'({bus.reset_vxv1, bus.reset_mxv1}), 64'(2'b10));
            step();
            check("t4_no_vxv1_reads", 64'(rd1 - base1), 64'(0));
         end
      end
      wait_done(5);

      // T5: aborted stream, then reset in UPDATE, then a clean one-beat restart.
      bus.total = 32'd40; bus.max_iter = 16'd0;
      base1 = rd1;
      bus.go = 1'b1; step(); bus.go = 1'b0;
      step(); step();
      bus.vxv1_result = 32'h3F800000;
      pulse(F_VXV1);
      repeat (6) step();
      check("abort_stream", 64'(rd1 - base1), 64'(2));
      pulse(F_MXV);
      pulse(F_DIV1);
      check("t5_in_update", 64'(bus.start_mul_add), 64'(1));
      reset = 1'b0;
      #1;
      check("t5_reset_levels",
            64'({bus.reset_vxv1, bus.reset_mxv1, bus.start_mul_add, bus.vxv3_start,
                 bus.start_div2, bus.busy, bus.done}), 64'(7'b1100000));
      check("t5_rsold_cleared", 64'(bus.rsold), 64'(0));
      step(); step();
      reset = 1'b1;
      step();
      bus.total = 32'd0;
      sb_q.push_back(predict(32'h40000000, 32'h00000000, 16'd0));
      base1 = rd1;
      bus.go = 1'b1; step(); bus.go = 1'b0;
      repeat (5) step();
      check("t5_total0_one_beat", 64'(rd1 - base1), 64'(1));
      bus.vxv1_result = 32'h40000000;
      pulse(F_VXV1);
      pulse(F_MXV);
      pulse(F_DIV1);
      base3 = rd3;
      pulse(F_MA2);
      repeat (4) step();
      check("t5_vxv3_one_beat", 64'(rd3 - base3), 64'(1));
      bus.vxv3_result = 32'h00000000;
      pulse(F_VXV3);
      wait_done(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
